multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of MEM-state cycles spent waiting for mem_ack_i.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  run enable; level-sensitive.
REQ-005 Op_i  in  7  opcode field of the instruction register.
REQ-006 mem_ack_i  in  1  data memory has completed the current access.
REQ-007 ALUOp_o  out  2  00 R-type, 01 I-type, 10 address add, 11 branch compare.
REQ-008 ALUSrc_o  out  1  1 selects immediate as ALU operand B.
REQ-009 RegWrite_o  out  1  register file write strobe.
REQ-010 MemToReg_o  out  1  1 selects memory data for write-back.
REQ-011 MemRead_o  out  1  data memory read request.
REQ-012 MemWrite_o  out  1  data memory write request.
REQ-013 Branch_o  out  1  branch-compare cycle; PC logic qualifies it with zero flag.
REQ-014 PCWrite_o  out  1  PC+4 update strobe.
REQ-015 IRWrite_o  out  1  instruction register load strobe.
REQ-016 illegal_o  out  1  one-cycle pulse on an unsupported opcode.
REQ-017 err_o  out  1  sticky memory-timeout flag.
REQ-018 busy_o  out  1  high in every state except IDLE.
REQ-019 retired_o  out  16  retired-instruction count; wraps modulo 2^16.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Outputs are Moore outputs, decoded from the state register and the opcode latched in DECODE.
REQ-021 IDLE: all strobes are 0. start_i=1 -> FETCH.
REQ-022 FETCH: lasts one cycle, IRWrite_o=1 and PCWrite_o=1 -> DECODE.
REQ-023 DECODE: latches Op_i. Supported opcodes are 0110011 R, 0010011 I, 0000011 LW, 0100011 SW and 1100011 BEQ -> EXEC. Any other opcode pulses illegal_o, does not retire, and exits per REQ-028.
REQ-024 EXEC drives ALUOp_o and ALUSrc_o:
- R: 00/0, next WB.
- I: 01/1, next WB.
- LW/SW: 10/1, next MEM.
- BEQ: 11/0 with Branch_o=1, then retires and exits per REQ-028.
REQ-025 MEM holds ALUOp_o=10 and ALUSrc_o=1, and asserts MemRead_o (LW) or MemWrite_o (SW) continuously until mem_ack_i is sampled 1. After the ack, LW -> WB, and SW retires and exits per REQ-028.
REQ-026 MEM wait counter:
- Counts cycles in MEM and clears on MEM entry.
- If no ack after TIMEOUT cycles: drop the request, set err_o, retire nothing, go to IDLE.
- An ack in the same cycle the count reaches TIMEOUT counts as success.
REQ-027 WB: lasts one cycle with RegWrite_o=1; MemToReg_o=1 only for LW. Then retire and exit per REQ-028.
REQ-028 Exit: start_i=1 -> FETCH, start_i=0 -> IDLE. Dropping start_i mid-instruction never aborts it.
REQ-029 Latency from FETCH to retire: R/I 4 cycles, BEQ 3, SW 4+w, LW 5+w, where w is the number of MEM wait cycles (0 when ack arrives in the first MEM cycle).
REQ-030 retired_o increments by exactly 1 in the retire cycle; 16'hFFFF wraps to 0.
REQ-031 err_o clears only on reset. start_i restarts the controller from IDLE even while err_o=1.

Reset
REQ-032 When rst_i=1 at a clock edge, the next state is IDLE from any state, including mid-MEM, and the following are cleared: latched opcode, wait counter, retired_o=0, err_o=0, all strobes=0, ALUOp_o=00.
REQ-033 While rst_i=1, all inputs are ignored.

Structure
REQ-034 Shared package ctrl_pkg holds:
- opcode constants;
- ALUOp encodings;
- state enum;
- default TIMEOUT.
REQ-035 Sub-module main_decoder is purely combinational: opcode -> {class, ALUOp, ALUSrc, legal}. It is instantiated once; the FSM lives in the top module.

Verification
REQ-036 Reset, then start_i=1 with Op_i=0110011: FETCH/DECODE/EXEC/WB; RegWrite_o=1 in cycle 4 only; retired_o=1.
REQ-037 LW with mem_ack_i delayed 3 cycles: MemRead_o high for 4 cycles; WB has MemToReg_o=1; retire after 8 cycles.
REQ-038 SW with no ack and TIMEOUT=15: MemWrite_o drops after 15 MEM cycles; err_o=1; state IDLE; retired_o unchanged.
REQ-039 Op_i=1111111: illegal_o pulses for 1 cycle in DECODE, no RegWrite_o, next state FETCH; BEQ gives Branch_o=1 for 1 cycle with ALUOp_o=11.
REQ-040 rst_i asserted mid-MEM, and start_i dropped during EXEC of an R-type: reset gives IDLE with all outputs 0 the next cycle; the dropped start_i still completes WB, then IDLE. Preload 16'hFFFF retires and check wrap to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALUOp encodings,
// FSM states and the decoded instruction class.
package ctrl_pkg;

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  localparam logic [1:0] AluOpR    = 2'b00;
  localparam logic [1:0] AluOpI    = 2'b01;
  localparam logic [1:0] AluOpAddr = 2'b10;
  localparam logic [1:0] AluOpBr   = 2'b11;

  localparam int unsigned DefaultTimeout = 15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsIllegal
  } op_class_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake and control-strobe bundle between the controller and its datapath.
interface multicycle_control_if;
  logic        start_i;
  logic [6:0]  Op_i;
  logic        mem_ack_i;
  logic [1:0]  ALUOp_o;
  logic        ALUSrc_o;
  logic        RegWrite_o;
  logic        MemToReg_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        Branch_o;
  logic        PCWrite_o;
  logic        IRWrite_o;
  logic        illegal_o;
  logic        err_o;
  logic        busy_o;
  logic [15:0] retired_o;

  modport slave (
    input  start_i, Op_i, mem_ack_i,
    output ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
           Branch_o, PCWrite_o, IRWrite_o, illegal_o, err_o, busy_o, retired_o
  );

  modport master (
    output start_i, Op_i, mem_ack_i,
    input  ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
           Branch_o, PCWrite_o, IRWrite_o, illegal_o, err_o, busy_o, retired_o
  );
endinterface

// File: rtl/main_decoder.sv
// Combinational opcode decoder: instruction class, ALU operation, operand-B
// select and legality.
module main_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output op_class_e  class_o,
  output logic [1:0] alu_op_o,
  output logic       alu_src_o,
  output logic       legal_o
);

  always_comb begin
    class_o   = ClsIllegal;
    alu_op_o  = AluOpR;
    alu_src_o = 1'b0;
    legal_o   = 1'b1;
    case (op_i)
      OpR: class_o = ClsR;
      OpI: begin
        class_o   = ClsI;
        alu_op_o  = AluOpI;
        alu_src_o = 1'b1;
      end
      OpLw: begin
        class_o   = ClsLw;
        alu_op_o  = AluOpAddr;
        alu_src_o = 1'b1;
      end
      OpSw: begin
        class_o   = ClsSw;
        alu_op_o  = AluOpAddr;
        alu_src_o = 1'b1;
      end
      OpBeq: begin
        class_o  = ClsBeq;
        alu_op_o = AluOpBr;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a bounded
// memory wait, sticky timeout error and a retired-instruction counter.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic                 clk_i,
  input logic                 rst_i,
  multicycle_control_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [15:0]     retired_q, retired_d;
  logic            retire;
  state_e          exit_st;

  logic [6:0]  dec_op;
  op_class_e   dec_class;
  logic [1:0]  dec_alu_op;
  logic        dec_alu_src;
  logic        dec_legal;

  // The opcode is only valid on Op_i during DECODE; later states use the latched copy.
  assign dec_op = (state_q == StDecode) ? bus.Op_i : op_q;

  main_decoder u_main_decoder (
    .op_i      (dec_op),
    .class_o   (dec_class),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src),
    .legal_o   (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    retired_d = retired_q;
    retire    = 1'b0;
    exit_st   = bus.start_i ? StFetch : StIdle;
    case (state_q)
      StIdle:   if (bus.start_i) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        op_d    = bus.Op_i;
        state_d = dec_legal ? StExec : exit_st;
      end
      StExec: begin
        cnt_d = '0;
        case (dec_class)
          ClsR, ClsI:   state_d = StWb;
          ClsLw, ClsSw: state_d = StMem;
          ClsBeq: begin
            retire  = 1'b1;
            state_d = exit_st;
          end
          default:      state_d = exit_st;
        endcase
      end
      StMem: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (bus.mem_ack_i) begin
          if (dec_class == ClsLw) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = exit_st;
          end
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = exit_st;
      end
      default: state_d = StIdle;
    endcase
    if (retire) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  logic [1:0] alu_op;
  logic       alu_src, reg_write, mem_to_reg, mem_read, mem_write;
  logic       branch, pc_write, ir_write, illegal;

  always_comb begin
    alu_op     = AluOpR;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      StDecode: illegal = ~dec_legal;
      StExec: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        branch  = (dec_class == ClsBeq);
      end
      StMem: begin
        alu_op    = AluOpAddr;
        alu_src   = 1'b1;
        mem_read  = (dec_class == ClsLw);
        mem_write = (dec_class == ClsSw);
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (dec_class == ClsLw);
      end
      default: ;
    endcase
  end

  assign bus.ALUOp_o    = alu_op;
  assign bus.ALUSrc_o   = alu_src;
  assign bus.RegWrite_o = reg_write;
  assign bus.MemToReg_o = mem_to_reg;
  assign bus.MemRead_o  = mem_read;
  assign bus.MemWrite_o = mem_write;
  assign bus.Branch_o   = branch;
  assign bus.PCWrite_o  = pc_write;
  assign bus.IRWrite_o  = ir_write;
  assign bus.illegal_o  = illegal;
  assign bus.err_o      = err_q;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand-written
// sequences for the memory timeout boundary, sticky error and counter wrap.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  multicycle_control_if bus ();

  multicycle_control #(
    .TIMEOUT (15)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {ALUOp[1:0], ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch,
  //  PCWrite, IRWrite, illegal, err, busy}
  localparam logic [12:0] C_IDLE   = 13'b00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] C_FETCH  = 13'b00_0_0_0_0_0_0_1_1_0_0_1;
  localparam logic [12:0] C_DEC    = 13'b00_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_DECILL = 13'b00_0_0_0_0_0_0_0_0_1_0_1;
  localparam logic [12:0] C_EX_R   = 13'b00_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_EX_I   = 13'b01_1_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_EX_M   = 13'b10_1_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_EX_BEQ = 13'b11_0_0_0_0_0_1_0_0_0_0_1;
  localparam logic [12:0] C_MEM_RD = 13'b10_1_0_0_1_0_0_0_0_0_0_1;
  localparam logic [12:0] C_MEM_WR = 13'b10_1_0_0_0_1_0_0_0_0_0_1;
  localparam logic [12:0] C_WB_ALU = 13'b00_0_1_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_WB_LW  = 13'b00_0_1_1_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_ERR    = 13'b00_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [6:0]  OpBad    = 7'b1111111;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic [6:0]  op;
    logic        ack;
    logic [12:0] exp_ctl;
    logic [15:0] exp_ret;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [12:0] ctl_now();
    return {bus.ALUOp_o, bus.ALUSrc_o, bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o,
            bus.MemWrite_o, bus.Branch_o, bus.PCWrite_o, bus.IRWrite_o, bus.illegal_o,
            bus.err_o, bus.busy_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs reflect the current state; the inputs driven here are sampled at the next edge.
  task automatic step(input string name, input logic r, input logic s, input logic [6:0] op,
                      input logic a, input logic [12:0] exp_ctl, input logic [15:0] exp_ret);
    @(negedge clk);
    rst           = r;
    bus.start_i   = s;
    bus.Op_i      = op;
    bus.mem_ack_i = a;
    #1;
    chk({name, ".ctl"}, {19'd0, ctl_now()}, {19'd0, exp_ctl});
    chk({name, ".ret"}, {16'd0, bus.retired_o}, {16'd0, exp_ret});
  endtask

  task automatic add(input string n, input logic r, input logic s, input logic [6:0] op,
                     input logic a, input logic [12:0] e, input logic [15:0] rt);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.op = op; v.ack = a; v.exp_ctl = e; v.exp_ret = rt;
    vecs.push_back(v);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.Op_i      = '0;
    bus.mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);

    // R-type, then I-type back to back
    add("r_idle",   0, 1, OpR,   0, C_IDLE,   0);
    add("r_fetch",  0, 1, OpR,   0, C_FETCH,  0);
    add("r_dec",    0, 1, OpR,   0, C_DEC,    0);
    add("r_exec",   0, 1, OpR,   0, C_EX_R,   0);
    add("r_wb",     0, 0, OpR,   0, C_WB_ALU, 0);
    add("r_done",   0, 1, OpI,   0, C_IDLE,   1);
    add("i_fetch",  0, 1, OpI,   0, C_FETCH,  1);
    add("i_dec",    0, 1, OpI,   0, C_DEC,    1);
    add("i_exec",   0, 1, OpI,   0, C_EX_I,   1);
    add("i_wb",     0, 1, OpLw,  0, C_WB_ALU, 1);
    // LW with ack on the fourth MEM cycle
    add("lw_fetch", 0, 1, OpLw,  0, C_FETCH,  2);
    add("lw_dec",   0, 1, OpLw,  0, C_DEC,    2);
    add("lw_exec",  0, 1, OpLw,  0, C_EX_M,   2);
    add("lw_mem1",  0, 1, OpLw,  0, C_MEM_RD, 2);
    add("lw_mem2",  0, 1, OpLw,  0, C_MEM_RD, 2);
    add("lw_mem3",  0, 1, OpLw,  0, C_MEM_RD, 2);
    add("lw_mem4",  0, 1, OpLw,  1, C_MEM_RD, 2);
    add("lw_wb",    0, 0, OpLw,  0, C_WB_LW,  2);
    add("lw_done",  0, 1, OpSw,  0, C_IDLE,   3);
    // SW acked immediately, start held so BEQ follows
    add("sw_fetch", 0, 1, OpSw,  0, C_FETCH,  3);
    add("sw_dec",   0, 1, OpSw,  0, C_DEC,    3);
    add("sw_exec",  0, 1, OpSw,  0, C_EX_M,   3);
    add("sw_mem",   0, 1, OpSw,  1, C_MEM_WR, 3);
    add("beq_fetch",0, 1, OpBeq, 0, C_FETCH,  4);
    add("beq_dec",  0, 1, OpBeq, 0, C_DEC,    4);
    add("beq_exec", 0, 1, OpBeq, 0, C_EX_BEQ, 4);
    // Illegal opcode goes straight back to FETCH without retiring
    add("ill_fetch",0, 1, OpBad, 0, C_FETCH,  5);
    add("ill_dec",  0, 1, OpBad, 0, C_DECILL, 5);
    // start dropped during EXEC still completes WB
    add("drop_fetch",0, 1, OpR,  0, C_FETCH,  5);
    add("drop_dec", 0, 1, OpR,   0, C_DEC,    5);
    add("drop_exec",0, 0, OpR,   0, C_EX_R,   5);
    add("drop_wb",  0, 0, OpR,   0, C_WB_ALU, 5);
    add("drop_idle",0, 0, OpR,   0, C_IDLE,   6);
    // Reset mid-MEM; start and ack present during reset must be ignored
    add("rm_idle",  0, 1, OpLw,  0, C_IDLE,   6);
    add("rm_fetch", 0, 1, OpLw,  0, C_FETCH,  6);
    add("rm_dec",   0, 1, OpLw,  0, C_DEC,    6);
    add("rm_exec",  0, 1, OpLw,  0, C_EX_M,   6);
    add("rm_mem",   1, 1, OpLw,  1, C_MEM_RD, 6);
    add("rm_after", 0, 0, OpLw,  0, C_IDLE,   0);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].start, vecs[i].op, vecs[i].ack,
           vecs[i].exp_ctl, vecs[i].exp_ret);

    // LW acked on exactly the TIMEOUT-th MEM cycle counts as success
    step("a_idle", 0, 1, OpLw, 0, C_IDLE, 0);
    step("a_fetch", 0, 1, OpLw, 0, C_FETCH, 0);
    step("a_dec", 0, 1, OpLw, 0, C_DEC, 0);
    step("a_exec", 0, 0, OpLw, 0, C_EX_M, 0);
    for (int k = 0; k < 14; k++) step("a_mem_wait", 0, 0, OpLw, 0, C_MEM_RD, 0);
    step("a_mem_last", 0, 0, OpLw, 1, C_MEM_RD, 0);
    step("a_wb", 0, 0, OpLw, 0, C_WB_LW, 0);

    // SW never acked: request held 15 cycles, then IDLE with err set and no retire
    step("b_idle", 0, 1, OpSw, 0, C_IDLE, 1);
    step("b_fetch", 0, 1, OpSw, 0, C_FETCH, 1);
    step("b_dec", 0, 1, OpSw, 0, C_DEC, 1);
    step("b_exec", 0, 0, OpSw, 0, C_EX_M, 1);
    for (int k = 0; k < 15; k++) step("b_mem_wait", 0, 0, OpSw, 0, C_MEM_WR, 1);
    step("b_timeout", 0, 1, OpR, 0, C_IDLE | C_ERR, 1);
    step("b_fetch_err", 0, 1, OpR, 0, C_FETCH | C_ERR, 1);
    step("b_dec_err", 0, 1, OpR, 0, C_DEC | C_ERR, 1);
    step("b_exec_err", 0, 1, OpR, 0, C_EX_R | C_ERR, 1);
    step("b_wb_err", 0, 0, OpR, 0, C_WB_ALU | C_ERR, 1);
    step("c_reset", 1, 0, OpR, 0, C_IDLE | C_ERR, 2);
    step("c_cleared", 0, 0, OpR, 0, C_IDLE, 0);

    // Counter wrap: preload all-ones, then retire one BEQ
    force dut.retired_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.retired_q;
    step("w_idle", 0, 1, OpBeq, 0, C_IDLE, 16'hFFFF);
    step("w_fetch", 0, 1, OpBeq, 0, C_FETCH, 16'hFFFF);
    step("w_dec", 0, 1, OpBeq, 0, C_DEC, 16'hFFFF);
    step("w_exec", 0, 0, OpBeq, 0, C_EX_BEQ, 16'hFFFF);
    step("w_wrapped", 0, 0, OpBeq, 0, C_IDLE, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
